// File: rtl/hym_frame_filter.sv
// Validates and conditions 40-bit humidity/temperature frames before SPI readout.
// Optional median-of-three filtering is enabled by defining HYM_MEDIAN_EN.
module hym_frame_filter #(
  parameter int unsigned FAULT_LIMIT = 3,
  parameter int unsigned TIMEOUT_CYC = 12000000
) (
  input  logic        clk1M,
  input  logic        rst_n,
  input  logic [39:0] frame_in,
  input  logic        frame_stb,
  output logic [39:0] hym_out,
  output logic        hym_valid,
  output logic        update_stb,
  output logic [7:0]  err_cnt,
  output logic        sensor_fault,
  output logic [1:0]  state_dbg
);

  // Handshake: frame_stb is a one-cycle strobe with no ready; it is taken only
  // in IDLE and silently dropped in every other state. update_stb is a
  // one-cycle pulse that marks the cycle in which hym_out carries a new value.

  localparam logic [7:0]  FAULT_LIM = FAULT_LIMIT[7:0];
  localparam logic [23:0] TO_LIM    = TIMEOUT_CYC[23:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    FILTER  = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t state, state_next;

  logic [39:0] frame_q;
  logic        good_q;
  logic [15:0] hum_h0, tmp_h0;
  logic [15:0] hum_sel, tmp_sel;
  logic [15:0] hum_pick, tmp_pick;
  logic [7:0]  consec;
  logic [7:0]  consec_inc;
  logic [23:0] to_cnt;
  logic        to_hit;
  logic        bad_now, good_now;

  logic [7:0]  sum_in;
  logic [15:0] hum_in, tmag_in, tmp_2c;
  logic        frame_good;

  logic [15:0] tmp_mag, tmp_sm;
  logic [7:0]  out_sum;

`ifdef HYM_MEDIAN_EN
  logic [15:0] hum_h1, hum_h2, tmp_h1, tmp_h2;
  logic [1:0]  fill;

  function automatic logic [15:0] med_u(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic [15:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  function automatic logic [15:0] med_s(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic [15:0] lo, hi;
    lo = ($signed(a) < $signed(b)) ? a : b;
    hi = ($signed(a) < $signed(b)) ? b : a;
    return ($signed(c) < $signed(lo)) ? lo : (($signed(c) > $signed(hi)) ? hi : c);
  endfunction
`endif

  assign state_dbg = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk1M) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_stb) state_next = CHECK;
      CHECK:   state_next = FILTER;
      FILTER:  state_next = good_q ? PUBLISH : IDLE;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- frame check ----------------
  always_comb begin
    sum_in     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    hum_in     = frame_q[39:24];
    tmag_in    = {1'b0, frame_q[22:8]};
    tmp_2c     = frame_q[23] ? (16'd0 - tmag_in) : tmag_in;
    frame_good = (sum_in == frame_q[7:0]) &&
                 (hum_in <= 16'd1000) &&
                 (frame_q[23] ? (tmag_in <= 16'd400) : (tmag_in <= 16'd800));
  end

  always_ff @(posedge clk1M) begin
    if (!rst_n) begin
      frame_q <= '0;
      good_q  <= 1'b0;
    end else begin
      if (state == IDLE && frame_stb) frame_q <= frame_in;
      if (state == CHECK) good_q <= frame_good;
    end
  end

  // ---------------- history (newest in slot 0) ----------------
  always_ff @(posedge clk1M) begin
    if (!rst_n) begin
      hum_h0 <= '0;
      tmp_h0 <= '0;
`ifdef HYM_MEDIAN_EN
      hum_h1 <= '0;
      hum_h2 <= '0;
      tmp_h1 <= '0;
      tmp_h2 <= '0;
      fill   <= '0;
`endif
    end else if (state == CHECK && frame_good) begin
      hum_h0 <= hum_in;
      tmp_h0 <= tmp_2c;
`ifdef HYM_MEDIAN_EN
      hum_h1 <= hum_h0;
      hum_h2 <= hum_h1;
      tmp_h1 <= tmp_h0;
      tmp_h2 <= tmp_h1;
      if (fill != 2'd3) fill <= fill + 2'd1;
`endif
    end
  end

  // ---------------- filter selection ----------------
  always_comb begin
    hum_pick = hum_h0;
    tmp_pick = tmp_h0;
`ifdef HYM_MEDIAN_EN
    if (fill == 2'd3) begin
      hum_pick = med_u(hum_h0, hum_h1, hum_h2);
      tmp_pick = med_s(tmp_h0, tmp_h1, tmp_h2);
    end
`endif
  end

  always_ff @(posedge clk1M) begin
    if (!rst_n) begin
      hum_sel <= '0;
      tmp_sel <= '0;
    end else if (state == FILTER && good_q) begin
      hum_sel <= hum_pick;
      tmp_sel <= tmp_pick;
    end
  end

  // ---------------- re-encode and publish ----------------
  // A two's-complement zero has sign bit 0, so -0 can never be produced here.
  always_comb begin
    tmp_mag = tmp_sel[15] ? (16'd0 - tmp_sel) : tmp_sel;
    tmp_sm  = {tmp_sel[15], tmp_mag[14:0]};
    out_sum = hum_sel[15:8] + hum_sel[7:0] + tmp_sm[15:8] + tmp_sm[7:0];
  end

  always_ff @(posedge clk1M) begin
    if (!rst_n) begin
      hym_out    <= '0;
      hym_valid  <= 1'b0;
      update_stb <= 1'b0;
    end else begin
      update_stb <= (state == PUBLISH);
      if (state == PUBLISH) begin
        hym_out   <= {hum_sel, tmp_sm, out_sum};
        hym_valid <= 1'b1;
      end
    end
  end

  // ---------------- error / timeout status ----------------
  always_comb begin
    bad_now    = (state == FILTER) && !good_q;
    good_now   = (state == FILTER) && good_q;
    consec_inc = (consec < FAULT_LIM) ? consec + 8'd1 : consec;
    to_hit     = !frame_stb && ((to_cnt == TO_LIM) || (to_cnt + 24'd1 == TO_LIM));
  end

  always_ff @(posedge clk1M) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      consec       <= '0;
      err_cnt      <= '0;
      sensor_fault <= 1'b0;
    end else begin
      if (frame_stb)            to_cnt <= '0;
      else if (to_cnt < TO_LIM) to_cnt <= to_cnt + 24'd1;

      if (bad_now) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        consec <= consec_inc;
      end else if (good_now) begin
        consec <= '0;
      end

      // A good-frame clear outranks a timeout landing in the same cycle.
      if (good_now)
        sensor_fault <= 1'b0;
      else if ((bad_now && consec_inc == FAULT_LIM) || to_hit)
        sensor_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hym_frame_filter.sv
// Self-checking bench for hym_frame_filter: vector table, scoreboard queue and
// hand-written sequences for timeout, ignored strobes and mid-frame reset.
module tb_hym_frame_filter;

  localparam int TO  = 100;
  localparam int LIM = 3;

  // ---------------- clock / reset ----------------
  logic        clk1M = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] frame_in = '0;
  logic        frame_stb = 1'b0;
  logic [39:0] hym_out;
  logic        hym_valid, update_stb, sensor_fault;
  logic [7:0]  err_cnt;
  logic [1:0]  state_dbg;

  always #5 clk1M = ~clk1M;

  hym_frame_filter #(.FAULT_LIMIT(LIM), .TIMEOUT_CYC(TO)) dut (
    .clk1M(clk1M), .rst_n(rst_n), .frame_in(frame_in), .frame_stb(frame_stb),
    .hym_out(hym_out), .hym_valid(hym_valid), .update_stb(update_stb),
    .err_cnt(err_cnt), .sensor_fault(sensor_fault), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  int          m_h[3], m_t[3];
  int          m_fill, m_err, m_consec;
  logic        m_fault;
  logic [39:0] m_out;

  typedef struct {
    logic [39:0] frame;
    logic        good;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int h, input logic [15:0] t);
    logic [39:0] f;
    f[39:24] = 16'(h);
    f[23:8]  = t;
    f[7:0]   = 8'((int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256);
    return f;
  endfunction

  function automatic int med3(input int a, input int b, input int c);
    int s[3];
    int tmp;
    s[0] = a; s[1] = b; s[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin
          tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
        end
    return s[1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_h[i] = 0; m_t[i] = 0;
    end
    m_fill = 0; m_err = 0; m_consec = 0; m_fault = 1'b0; m_out = '0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [39:0] f, output logic good);
    int sum, h, mag, t, sel_h, sel_t;
    logic [15:0] tenc;
    sum  = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    h    = int'(f[39:24]);
    mag  = int'(f[22:8]);
    good = (sum == int'(f[7:0])) && (h <= 1000) && (f[23] ? (mag <= 400) : (mag <= 800));
    if (good) begin
      t = f[23] ? -mag : mag;
      m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = h;
      m_t[2] = m_t[1]; m_t[1] = m_t[0]; m_t[0] = t;
      if (m_fill < 3) m_fill++;
      sel_h = h;
      sel_t = t;
`ifdef HYM_MEDIAN_EN
      if (m_fill == 3) begin
        sel_h = med3(m_h[0], m_h[1], m_h[2]);
        sel_t = med3(m_t[0], m_t[1], m_t[2]);
      end
`endif
      tenc = (sel_t < 0) ? {1'b1, 15'(-sel_t)} : 16'(sel_t);
      m_out = mk(sel_h, tenc);
      exp_q.push_back(m_out);
      m_consec = 0;
      m_fault  = 1'b0;
    end else begin
      if (m_err < 255) m_err++;
      if (m_consec < LIM) m_consec++;
      if (m_consec == LIM) m_fault = 1'b1;
    end
  endtask

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    frame_stb = 1'b0;
    repeat (2) @(negedge clk1M);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_frame(input logic [39:0] f, output logic seen);
    int err_before;
    logic good;
    logic [39:0] exp;
    err_before = m_err;
    model_frame(f, good);
    frame_in  = f;
    frame_stb = 1'b1;
    @(negedge clk1M);                      // edge 0 sampled the strobe
    frame_stb = 1'b0;
    @(negedge clk1M);                      // after edge 1
    chk("err_cnt_edge1", 40'(err_cnt), 40'(err_before));
    chk("update_edge1", 40'(update_stb), 40'd0);
    @(negedge clk1M);                      // after edge 2
    chk("err_cnt_edge2", 40'(err_cnt), 40'(m_err));
    chk("fault_edge2", 40'(sensor_fault), 40'(m_fault));
    chk("update_edge2", 40'(update_stb), 40'd0);
    @(negedge clk1M);                      // after edge 3
    seen = update_stb;
    if (good) begin
      chk("update_edge3", 40'(update_stb), 40'd1);
      exp = exp_q.pop_front();
      chk("hym_out", hym_out, exp);
      chk("hym_valid", 40'(hym_valid), 40'd1);
    end else begin
      chk("no_update_bad", 40'(update_stb), 40'd0);
      chk("hym_out_hold", hym_out, m_out);
    end
  endtask

  // ---------------- test ----------------
  vec_t vt[8];
  logic seen;
  int   n_upd;
  int   med_hum[4];
  logic [39:0] exp_w;

  initial begin
    vt[0] = '{mk(1000, 16'd800), 1'b1};
    vt[1] = '{mk(1001, 16'd100), 1'b0};
    vt[2] = '{mk(200, 16'd801), 1'b0};
    vt[3] = '{mk(200, 16'h8190), 1'b1};
    vt[4] = '{mk(200, 16'h8191), 1'b0};
    vt[5] = '{mk(0, 16'h8000), 1'b1};
    vt[6] = '{mk(300, 16'h0123) ^ 40'h1, 1'b0};
    vt[7] = '{mk(0, 16'h0000), 1'b1};
    med_hum[0] = 500; med_hum[1] = 900; med_hum[2] = 510; med_hum[3] = 520;

    @(negedge clk1M);
    do_reset();
    chk("reset_hym_out", hym_out, 40'd0);
    chk("reset_valid", 40'(hym_valid), 40'd0);
    chk("reset_update", 40'(update_stb), 40'd0);
    chk("reset_err_cnt", 40'(err_cnt), 40'd0);
    chk("reset_fault", 40'(sensor_fault), 40'd0);
    chk("reset_state", 40'(state_dbg), 40'd0);

    // first good frame, then three checksum errors, then recovery
    send_frame(40'h0292010499, seen);
    chk("first_frame", hym_out, 40'h0292010499);
    for (int i = 0; i < 3; i++) send_frame(40'h0292010400, seen);
    chk("bad3_err_cnt", 40'(err_cnt), 40'd3);
    chk("bad3_fault", 40'(sensor_fault), 40'd1);
    chk("bad3_hold", hym_out, 40'h0292010499);
    send_frame(40'h0292010499, seen);
    chk("fault_cleared", 40'(sensor_fault), 40'd0);

    // boundary vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].frame, seen);
      chk($sformatf("tbl_update_%0d", i), 40'(seen), 40'(vt[i].good));
    end
    chk("tbl_err_cnt", 40'(err_cnt), 40'd4);

    // negative zero is published as +0
    do_reset();
    send_frame(mk(300, 16'h8000), seen);
    chk("neg_zero", hym_out, mk(300, 16'h0000));

    // humidity sequence (median and pass-through agree on these outputs)
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(mk(med_hum[i], 16'h00C8), seen);
      chk($sformatf("med_hum_%0d", i), 40'(hym_out[39:24]), 40'(med_hum[i]));
    end

    // negative temperature, then range rejects
    do_reset();
    send_frame(mk(400, 16'h0064), seen);
    send_frame(mk(400, 16'h0032), seen);
    send_frame(mk(400, 16'h80C8), seen);
`ifdef HYM_MEDIAN_EN
    chk("neg_median", hym_out, mk(400, 16'h0032));
`else
    chk("neg_newest", hym_out, mk(400, 16'h80C8));
`endif
    send_frame(mk(400, 16'h8191), seen);
    send_frame(mk(16'h03E9, 16'h0064), seen);
    chk("range_err_cnt", 40'(err_cnt), 40'd2);

    // timeout
    do_reset();
    repeat (TO - 1) @(negedge clk1M);
    chk("timeout_before", 40'(sensor_fault), 40'd0);
    @(negedge clk1M);
    chk("timeout_at", 40'(sensor_fault), 40'd1);
    m_fault = 1'b1;
    send_frame(40'h0292010400, seen);
    chk("timeout_bad_keeps", 40'(sensor_fault), 40'd1);
    send_frame(40'h0292010499, seen);
    chk("timeout_cleared", 40'(sensor_fault), 40'd0);
    repeat (TO - 10) @(negedge clk1M);
    chk("timeout_restarted", 40'(sensor_fault), 40'd0);

    // strobes 1 and 2 cycles after an accepted one are ignored
    model_frame(mk(450, 16'h00FA), seen);
    exp_w = exp_q.pop_front();
    frame_in = mk(450, 16'h00FA);
    frame_stb = 1'b1;
    @(negedge clk1M);
    frame_in = mk(999, 16'h0001);
    @(negedge clk1M);
    @(negedge clk1M);
    frame_stb = 1'b0;
    n_upd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1M);
      if (update_stb) n_upd++;
    end
    chk("ignored_one_update", 40'(n_upd), 40'd1);
    chk("ignored_hym_out", hym_out, exp_w);

    // reset during CHECK aborts the frame
    frame_in = mk(123, 16'h0045);
    frame_stb = 1'b1;
    @(negedge clk1M);
    frame_stb = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1M);
    rst_n = 1'b1;
    model_reset();
    n_upd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1M);
      if (update_stb) n_upd++;
    end
    chk("abort_no_update", 40'(n_upd), 40'd0);
    chk("abort_hym_out", hym_out, 40'd0);
    chk("abort_valid", 40'(hym_valid), 40'd0);
    chk("abort_err_cnt", 40'(err_cnt), 40'd0);
    chk("abort_fault", 40'(sensor_fault), 40'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hym_frame_filter.md
# hym_frame_filter

Validates and conditions the 40-bit humidity/temperature frames produced by the Humidity sensor reader before they reach the SPI slave readout path. It sits between Humidity (producer of the raw frame) and SPI_slave (consumer of the conditioned 40-bit word). It does the following:
- checks the frame checksum and physical range;
- optionally median-filters the last three good readings;
- re-encodes a self-consistent frame for readout;
- tracks error and timeout status.

## Interface
Parameters:
- FAULT_LIMIT, 3, consecutive bad frames that raise sensor_fault (1..255)
- TIMEOUT_CYC, 12000000, clk1M cycles without frame_stb that raise sensor_fault (fits 24 bits)

Ports (one clock; reset is synchronous and active-low):
- clk1M  input  1  1 MHz system clock from frqdiv; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- frame_in  input  40  raw frame: [39:24] humidity x10, [23:8] temperature x10 sign-magnitude (bit 23 = sign), [7:0] checksum
- frame_stb  input  1  one-cycle strobe; frame_in valid on this cycle
- hym_out  output  40  conditioned frame, same format, checksum recomputed
- hym_valid  output  1  high once at least one good frame has been published
- update_stb  output  1  one-cycle pulse when hym_out changes
- err_cnt  output  8  saturating count of bad frames since reset
- sensor_fault  output  1  sensor considered failed

## Operation
- FSM states: IDLE, CHECK, FILTER, PUBLISH.
- IDLE:
  - On frame_stb, register frame_in and go to CHECK.
  - frame_stb in any other state is ignored. It is not queued and not counted.
- CHECK: the frame is good when all of the following hold; otherwise it is bad:
  - The checksum matches: (b4+b3+b2+b1) mod 256 == b0, where b4..b0 are frame bytes MSB first.
  - Humidity ≤ 1000.
  - Temperature magnitude ≤ 800 when positive, ≤ 400 when negative.
  - Negative zero (0x8000) is accepted as 0.
- Bad frame handling:
  - err_cnt is incremented, saturating at 255.
  - The consecutive-bad counter is incremented, saturating at FAULT_LIMIT.
  - When it reaches FAULT_LIMIT, sensor_fault is set.
  - The FSM returns to IDLE; hym_out is unchanged and there is no update_stb.
- Good frame handling:
  - The consecutive-bad counter is cleared and sensor_fault is cleared.
  - Temperature is converted to 16-bit two's complement.
  - The sample is pushed into a 3-deep history for humidity and for temperature (shift; oldest dropped).
  - The history fill count saturates at 3.
  - Next state is FILTER.
- FILTER:
  - Humidity and temperature are each selected independently (see Configuration).
  - Temperature is compared signed; humidity unsigned.
- PUBLISH:
  - Temperature is converted back to sign-magnitude; -0 is encoded as 0x0000.
  - hym_out is assembled with a recomputed checksum.
  - hym_valid is set and update_stb is pulsed.
  - The FSM returns to IDLE.
- Timeout:
  - A 24-bit counter is cleared on every frame_stb, whatever the state.
  - Otherwise it increments, saturating at TIMEOUT_CYC.
  - At TIMEOUT_CYC, sensor_fault is set.
  - sensor_fault is cleared only by a subsequent good frame.
- When the timeout and a good frame clear occur in the same cycle, the clear wins.

## Timing
- Reset: hym_out=0, hym_valid=0, update_stb=0, err_cnt=0, sensor_fault=0, history and fill count cleared, both counters cleared, FSM in IDLE.
- Reset asserted mid-frame aborts processing; nothing is published.
- Latency (frame_stb sampled at edge 0):
  - CHECK at edge 1; FILTER at edge 2.
  - hym_out, hym_valid and update_stb update at edge 3.
  - update_stb is high for exactly one cycle.
  - Back in IDLE after edge 3; a new frame_stb is accepted in the next cycle, giving a minimum spacing of 4 cycles.
- Bad-frame outputs (err_cnt, sensor_fault) update at edge 2.
- hym_out holds its value between updates, including while sensor_fault=1.

## Configuration
- HYM_MEDIAN_EN defined:
  - FILTER outputs the median of the 3 history entries.
  - While the fill count is < 3, the newest sample is used.
- HYM_MEDIAN_EN undefined:
  - FILTER passes the newest good sample.
  - The history registers beyond depth 1 are not instantiated.
  - Latency and all other behaviour are unchanged.

## Test plan
- Reset, then frame 0x0292_0104_99 (65.8 %, 26.0 °C, sum 0x99): update_stb exactly 3 cycles after frame_stb, hym_out=0x0292010499, hym_valid=1.
- Checksum error, frame 0x0292_0104_00, sent 3 times: err_cnt=3, sensor_fault=1 at the third frame's edge 2, hym_out unchanged. A following good frame clears sensor_fault.
- With HYM_MEDIAN_EN, humidity 500, 900, 510 (temperature 200, sum correct): published humidities 500, 900, 510. A fourth frame of 520 gives median 520 (history 900, 510, 520).
- Negative temperature 0x80C8 (-20.0 °C) with history 0x0064 and 0x0032 under HYM_MEDIAN_EN: median = 0x0032, re-encoded correctly. Range rejects are checked: 0x8191 (-40.1 °C) and humidity 0x03E9 (100.1 %) increment err_cnt.
- No frame_stb for TIMEOUT_CYC cycles (override TIMEOUT_CYC=100): sensor_fault=1 at cycle 100. A frame_stb resets the counter; a good frame clears the fault.
- frame_stb pulses 1 and 2 cycles after an accepted strobe: ignored, exactly one update_stb. Reset asserted at the CHECK cycle: no update_stb, all outputs zero.
